// File: rtl/ahb_fifo_wr_ctrl.sv
// AHB-Lite write-only slave front end for an asynchronous FIFO.
// Legal write transfers are captured in the address phase and pushed as
// {addr, size, wdata} in the data phase. The FIFO full flag stretches the
// data phase with wait states. Reads, oversize and misaligned transfers get
// a two-cycle ERROR response and never reach the FIFO.
module ahb_fifo_wr_ctrl #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int ENTRY_W = ADDR_W + 3 + DATA_W
) (
  input  logic               w_clk,
  input  logic               w_rstn,
  input  logic               HSEL,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [2:0]         HSIZE,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  input  logic               full,
  output logic               w_inc,
  output logic [ENTRY_W-1:0] w_data,
  output logic [15:0]        wr_cnt
);

  // Largest HSIZE the data bus can carry: 2 (word) on 32 bits, 3 on 64 bits.
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [15:0]       wr_cnt_r;
  logic              valid_s;
  logic              legal_s;
  logic              capture_s;
  logic              unused_s;

  // True when the low address bits are a multiple of the transfer size.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr_lo[0] == 1'b0);
      3'd2:    ok = (addr_lo[1:0] == 2'b00);
      3'd3:    ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // NONSEQ and SEQ are distinguished only by HTRANS[1]; bit 0 is not needed.
  assign unused_s = HTRANS[0];

  assign valid_s = HSEL & HREADY & HTRANS[1];
  assign legal_s = valid_s & HWRITE & (HSIZE <= MAX_SIZE) & is_aligned(HADDR[2:0], HSIZE);
  assign wr_cnt  = wr_cnt_r;

  // Next-state decode and bus/FIFO outputs; outputs follow state and full directly
  // so a stall or push takes effect in the same cycle the FIFO flag changes.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    w_inc       = 1'b0;
    w_data      = '0;
    case (state_r)
      IDLE: begin
        if (valid_s) begin
          if (legal_s) begin
            state_nxt_s = DATA;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ERR1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        w_data    = {addr_q, size_q, HWDATA};
        HREADYOUT = ~full;
        w_inc     = ~full;
        if (full) begin
          // Master holds HWDATA; retry the push next cycle.
          state_nxt_s = DATA;
        end else if (valid_s) begin
          if (legal_s) begin
            state_nxt_s = DATA;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ERR1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ERR1: begin
        // First ERROR cycle: wait state so the master can cancel its next transfer.
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        state_nxt_s = ERR2;
      end
      ERR2: begin
        HRESP = 1'b1;
        if (valid_s) begin
          if (legal_s) begin
            state_nxt_s = DATA;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ERR1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; reset drops any pending entry without pushing it.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address-phase capture of the transfer that will be pushed in its data phase.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      addr_q <= '0;
      size_q <= 3'd0;
    end else if (capture_s) begin
      addr_q <= HADDR;
      size_q <= HSIZE;
    end else begin
      addr_q <= addr_q;
      size_q <= size_q;
    end
  end

  // Running count of completed pushes, wrapping at 16 bits.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      wr_cnt_r <= 16'd0;
    end else if (w_inc) begin
      wr_cnt_r <= wr_cnt_r + 16'd1;
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

endmodule

// File: tb/tb_ahb_fifo_wr_ctrl.sv
// Directed testbench for ahb_fifo_wr_ctrl (ADDR_W=32, DATA_W=32).
module tb_ahb_fifo_wr_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = ADDR_W + 3 + DATA_W;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic               w_clk;
  logic               w_rstn;
  logic               hsel;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [ADDR_W-1:0]  haddr;
  logic [2:0]         hsize;
  logic [DATA_W-1:0]  hwdata;
  logic               hready;
  logic               hreadyout;
  logic               hresp;
  logic               full;
  logic               w_inc;
  logic [ENTRY_W-1:0] w_data;
  logic [15:0]        wr_cnt;

  int n_checks;
  int n_errors;

  // Single-slave bus: the bus-wide ready is this slave's ready.
  assign hready = hreadyout;

  ahb_fifo_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .w_clk     (w_clk),
    .w_rstn    (w_rstn),
    .HSEL      (hsel),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HADDR     (haddr),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .full      (full),
    .w_inc     (w_inc),
    .w_data    (w_data),
    .wr_cnt    (wr_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge w_clk);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] t, input logic wr, input logic [31:0] a, input logic [2:0] s);
    hsel   = 1'b1;
    htrans = t;
    hwrite = wr;
    haddr  = a;
    hsize  = s;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = T_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'd0;
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    b2b_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    b2b_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    w_rstn = 1'b0;
    full   = 1'b0;
    hwdata = 32'h0;
    bus_idle();

    // Reset values
    repeat (2) @(negedge w_clk);
    check("rst_hreadyout", hreadyout, 1'b1);
    check("rst_hresp", hresp, 1'b0);
    check("rst_w_inc", w_inc, 1'b0);
    check("rst_wr_cnt", wr_cnt, 16'd0);
    next_cycle();
    w_rstn = 1'b1;
    next_cycle();

    // Unselected NONSEQ write: ignored
    addr_phase(T_NONSEQ, 1'b1, 32'h10, 3'd2);
    hsel = 1'b0;
    next_cycle();
    bus_idle();
    @(negedge w_clk);
    check("nosel_w_inc", w_inc, 1'b0);
    check("nosel_hreadyout", hreadyout, 1'b1);
    next_cycle();

    // Single write 0x10, word, 0xA5A5A5A5
    addr_phase(T_NONSEQ, 1'b1, 32'h10, 3'd2);
    @(negedge w_clk);
    check("single_addr_w_inc", w_inc, 1'b0);
    next_cycle();
    bus_idle();
    hwdata = 32'hA5A5A5A5;
    @(negedge w_clk);
    check("single_w_inc", w_inc, 1'b1);
    check("single_w_data", w_data, {32'h10, 3'd2, 32'hA5A5A5A5});
    check("single_hreadyout", hreadyout, 1'b1);
    check("single_hresp", hresp, 1'b0);
    next_cycle();
    @(negedge w_clk);
    check("single_w_inc_after", w_inc, 1'b0);
    check("single_wr_cnt", wr_cnt, 16'd1);

    // Four back-to-back writes, no wait states
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i < 4) addr_phase((i == 0) ? T_NONSEQ : T_SEQ, 1'b1, b2b_addr[i], 3'd2);
      else bus_idle();
      if (i > 0) hwdata = b2b_data[i-1];
      @(negedge w_clk);
      check($sformatf("b2b_w_inc_%0d", i), w_inc, (i > 0) ? 1'b1 : 1'b0);
      check($sformatf("b2b_hreadyout_%0d", i), hreadyout, 1'b1);
      if (i > 0) check($sformatf("b2b_w_data_%0d", i), w_data, {b2b_addr[i-1], 3'd2, b2b_data[i-1]});
    end
    next_cycle();
    @(negedge w_clk);
    check("b2b_wr_cnt", wr_cnt, 16'd5);

    // Full for 3 cycles, push on the 4th
    next_cycle();
    addr_phase(T_NONSEQ, 1'b1, 32'h200, 3'd2);
    next_cycle();
    bus_idle();
    hwdata = 32'hDEADBEEF;
    full   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge w_clk);
      check($sformatf("stall_hreadyout_%0d", i), hreadyout, 1'b0);
      check($sformatf("stall_w_inc_%0d", i), w_inc, 1'b0);
      next_cycle();
    end
    full = 1'b0;
    @(negedge w_clk);
    check("stall_push_w_inc", w_inc, 1'b1);
    check("stall_push_hreadyout", hreadyout, 1'b1);
    check("stall_push_w_data", w_data, {32'h200, 3'd2, 32'hDEADBEEF});
    next_cycle();
    @(negedge w_clk);
    check("stall_w_inc_after", w_inc, 1'b0);
    check("stall_wr_cnt", wr_cnt, 16'd6);

    // Read at 0x20 -> two-cycle ERROR
    next_cycle();
    addr_phase(T_NONSEQ, 1'b0, 32'h20, 3'd2);
    next_cycle();
    bus_idle();
    @(negedge w_clk);
    check("rd_err1_hreadyout", hreadyout, 1'b0);
    check("rd_err1_hresp", hresp, 1'b1);
    check("rd_err1_w_inc", w_inc, 1'b0);
    next_cycle();
    @(negedge w_clk);
    check("rd_err2_hreadyout", hreadyout, 1'b1);
    check("rd_err2_hresp", hresp, 1'b1);
    check("rd_err2_w_inc", w_inc, 1'b0);
    next_cycle();
    @(negedge w_clk);
    check("rd_idle_hresp", hresp, 1'b0);

    // Misaligned word write 0x22; a byte write to 0x33 issued during ERR2
    next_cycle();
    addr_phase(T_NONSEQ, 1'b1, 32'h22, 3'd2);
    next_cycle();
    bus_idle();
    @(negedge w_clk);
    check("mis_err1_hreadyout", hreadyout, 1'b0);
    check("mis_err1_hresp", hresp, 1'b1);
    next_cycle();
    addr_phase(T_NONSEQ, 1'b1, 32'h33, 3'd0);
    @(negedge w_clk);
    check("mis_err2_hresp", hresp, 1'b1);
    check("mis_err2_w_inc", w_inc, 1'b0);
    check("mis_wr_cnt", wr_cnt, 16'd6);
    next_cycle();
    bus_idle();
    hwdata = 32'h000000C3;
    @(negedge w_clk);
    check("err2_byte_w_inc", w_inc, 1'b1);
    check("err2_byte_w_data", w_data, {32'h33, 3'd0, 32'h000000C3});
    check("err2_byte_hresp", hresp, 1'b0);

    // Oversize (doubleword on 32-bit bus) offered right as the push completes
    next_cycle();
    check("b2e_wr_cnt", wr_cnt, 16'd7);
    addr_phase(T_NONSEQ, 1'b1, 32'h40, 3'd2);
    next_cycle();
    addr_phase(T_NONSEQ, 1'b1, 32'h48, 3'd3);
    hwdata = 32'h55AA55AA;
    @(negedge w_clk);
    check("b2e_push_w_inc", w_inc, 1'b1);
    next_cycle();
    bus_idle();
    @(negedge w_clk);
    check("b2e_err1_hreadyout", hreadyout, 1'b0);
    check("b2e_err1_hresp", hresp, 1'b1);
    check("b2e_err1_w_inc", w_inc, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge w_clk);
    check("b2e_wr_cnt_after", wr_cnt, 16'd8);

    // Reset asserted during a full stall
    next_cycle();
    addr_phase(T_NONSEQ, 1'b1, 32'h300, 3'd2);
    next_cycle();
    bus_idle();
    hwdata = 32'hCAFEF00D;
    full   = 1'b1;
    @(negedge w_clk);
    check("rststall_hreadyout", hreadyout, 1'b0);
    #1 w_rstn = 1'b0;
    #1;
    check("rststall_async_hreadyout", hreadyout, 1'b1);
    check("rststall_async_hresp", hresp, 1'b0);
    check("rststall_async_w_inc", w_inc, 1'b0);
    check("rststall_async_wr_cnt", wr_cnt, 16'd0);
    next_cycle();
    full = 1'b0;
    next_cycle();
    w_rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge w_clk);
      check($sformatf("rststall_no_push_%0d", i), w_inc, 1'b0);
      next_cycle();
    end
    addr_phase(T_NONSEQ, 1'b1, 32'h400, 3'd2);
    next_cycle();
    bus_idle();
    hwdata = 32'h0BADCAFE;
    @(negedge w_clk);
    check("post_rst_w_inc", w_inc, 1'b1);
    check("post_rst_w_data", w_data, {32'h400, 3'd2, 32'h0BADCAFE});
    next_cycle();
    @(negedge w_clk);
    check("post_rst_wr_cnt", wr_cnt, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_fifo_wr_ctrl.md
AHB_FIFO_WR_CTRL -- requirements
Module: ahb_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AHB address width.
REQ-002 SHALL have parameter DATA_W, default 32: AHB data width, 32 or 64 only.
REQ-003 SHALL derive localparam ENTRY_W = ADDR_W + 3 + DATA_W: the FIFO entry width.
REQ-004 SHALL have port w_clk, input, 1 bit: write-domain clock; all state SHALL be on posedge.
REQ-005 SHALL have port w_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port HSEL, input, 1 bit: slave select.
REQ-007 SHALL have port HTRANS, input, 2 bits: transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 SHALL have port HWRITE, input, 1 bit: 1 = write.
REQ-009 SHALL have port HADDR, input, ADDR_W bits: address.
REQ-010 SHALL have port HSIZE, input, 3 bits: transfer size.
REQ-011 SHALL have port HWDATA, input, DATA_W bits: write data, valid in the data phase.
REQ-012 SHALL have port HREADY, input, 1 bit: bus ready, including this slave.
REQ-013 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-014 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-015 SHALL have port full, input, 1 bit: async-FIFO write-side full flag.
REQ-016 SHALL have port w_inc, output, 1 bit: FIFO push strobe.
REQ-017 SHALL have port w_data, output, ENTRY_W bits: FIFO entry {addr, size, wdata}.
REQ-018 SHALL have port wr_cnt, output, 16 bits: total accepted pushes, wrapping.

Function
REQ-019 SHALL implement an FSM with states IDLE, DATA, ERR1 and ERR2.
REQ-020 SHALL define a valid address phase as HSEL & HREADY & HTRANS[1].
REQ-021 SHALL treat a transfer as legal only when it is a valid address phase, HWRITE=1, HSIZE <= log2(DATA_W/8), and HADDR is aligned to HSIZE.
REQ-022 On a legal transfer, SHALL register HADDR and HSIZE into addr_q and size_q and enter DATA.
REQ-023 On a valid address phase that is not legal (a read, oversize or misaligned), SHALL enter ERR1 and push nothing.
REQ-024 On IDLE or BUSY, or when HSEL=0, SHALL take no action and respond OKAY with zero wait states.
REQ-025 In DATA, SHALL drive w_data = {addr_q, size_q, HWDATA} combinationally.
REQ-026 In DATA, SHALL drive w_inc = !full and HREADYOUT = !full.
REQ-027 In DATA with full=1, SHALL hold HREADYOUT=0 and w_inc=0, and stay in DATA, retrying every cycle; HWDATA is held by the master.
REQ-028 In DATA with full=0, SHALL complete the push in that cycle.
REQ-029 When the push in DATA completes and a new legal transfer is present in the same cycle, SHALL capture it and remain in DATA (back-to-back, zero-bubble).
REQ-030 When the push in DATA completes and an illegal transfer is present in the same cycle, SHALL go to ERR1; when no transfer is present, SHALL go to IDLE.
REQ-031 In ERR1, SHALL drive HREADYOUT=0 and HRESP=1, then go unconditionally to ERR2.
REQ-032 In ERR2, SHALL drive HREADYOUT=1 and HRESP=1, and sample any address phase as in IDLE.
REQ-033 In IDLE and DATA, SHALL drive HRESP=0.
REQ-034 SHALL never assert w_inc while full=1.
REQ-035 SHALL assert w_inc for at most one cycle per accepted transfer.
REQ-036 SHALL increment wr_cnt by 1 on every cycle with w_inc=1, wrapping 0xFFFF -> 0x0000.
REQ-037 SHALL sample HWDATA only in the DATA cycle in which the push completes.

Reset
REQ-038 While w_rstn=0, SHALL hold state=IDLE, HREADYOUT=1, HRESP=0, w_inc=0, wr_cnt=0, and addr_q/size_q=0.
REQ-039 SHALL apply reset asynchronously, including mid-transfer (DATA stall or ERR1), discarding any pending entry without a push.
REQ-040 After w_rstn deasserts, SHALL accept a transfer on the first valid address phase.

Verification
REQ-041 Single write, HADDR=0x10, HSIZE=2, HWDATA=0xA5A5A5A5, full=0 -> one w_inc pulse in the data phase; w_data={0x10,3'd2,0xA5A5A5A5}; HREADYOUT=1; wr_cnt=1.
REQ-042 Four back-to-back NONSEQ/SEQ writes, full=0 -> four consecutive w_inc cycles with no wait states; wr_cnt=4.
REQ-043 Write with full=1 for 3 cycles, then 0 -> HREADYOUT=0 for 3 cycles; w_inc=0 throughout the stall; a single push on the 4th cycle.
REQ-044 Read at 0x20 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no w_inc.
REQ-045 Word write to 0x22 (misaligned) -> two-cycle ERROR response; wr_cnt unchanged.
REQ-046 w_rstn asserted during a full-stall -> outputs at reset values immediately; no push after release; the next write pushes normally.
